vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between VGA scan-out line prefetch and a drawing writer.
- On each line_start from the VGA timing generator, it bursts one scanline of words from the RAM into the display line buffer.
- Drawing writes are granted only while the RAM port is free.
- Sits between the 800x600 timing generator, the framebuffer RAM and the line buffer feeding the RGB outputs.

Parameters:
ADDR_W, 15, framebuffer RAM word-address width
DATA_W, 16, RAM/line-buffer word width (1 bit per pixel)
WORDS, 50, words per visible line (800 px / DATA_W)
LINES, 600, visible lines per frame
LB_AW, 6, line-buffer address width (2^LB_AW >= WORDS)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
frame_start  in  1  1-cycle pulse at start of vertical blank; rewinds line base
line_start  in  1  1-cycle pulse during horizontal blank: fetch next line
wr_req  in  1  drawing write request; addr/data held stable until wr_ack
wr_addr  in  ADDR_W  drawing write word address
wr_data  in  DATA_W  drawing write data
wr_ack  out  1  1-cycle grant pulse; write performed this cycle
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after address
lb_we  out  1  line-buffer write enable
lb_addr  out  LB_AW  line-buffer write address
lb_wdata  out  DATA_W  line-buffer write data
busy  out  1  high while a line fetch occupies the RAM port
underrun  out  1  sticky: line_start arrived before previous fetch finished

Behaviour:
- Reset (async, RESET_N=0): state IDLE; all outputs 0; word_cnt=0, line_idx=0, next_base=0. Underrun clears only on reset.
- States:
  - IDLE: no fetch in progress.
  - FETCH: one read issued per cycle.
  - DRAIN: one cycle to capture the last read.
- IDLE -> FETCH on line_start when line_idx < LINES. On entry, latch base = next_base; then next_base += WORDS and line_idx += 1.
- line_start when line_idx == LINES: ignored; no fetch, no counter change.
- frame_start: next_base=0, line_idx=0.
  - Same cycle as line_start: frame_start applies first; the fetch uses base 0 and leaves line_idx=1, next_base=WORDS.
- FETCH, per cycle:
  - mem_addr = base + word_cnt, mem_we=0, busy=1; word_cnt increments.
  - After issuing word WORDS-1: word_cnt returns to 0 and state goes to DRAIN.
- Line-buffer write path: one cycle after each read, lb_we=1, lb_addr = index of that read, lb_wdata = mem_rdata. Reads and lb writes therefore overlap; lb writes run from cycle after first read to the DRAIN cycle.
- DRAIN: busy=0; performs the last lb write; returns to IDLE (or FETCH if line_start arrives this cycle).
- Fetch latency: first read is issued in the cycle after line_start. The line is complete WORDS+1 cycles after line_start.
- Drawing grant:
  - When state is IDLE or DRAIN, line_start=0 and wr_req=1, the arbiter drives mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1 and wr_ack=1, combinationally in that cycle.
  - Back-to-back grants are allowed every cycle.
- Priority: fetch has absolute priority. line_start together with wr_req gives no ack; the write waits until the fetch finishes.
- Underrun: line_start arriving while in FETCH sets underrun=1. The current fetch is aborted and restarted at word 0 with the next line base; in-flight lb writes still complete normally.
- wr_req dropped without ack: no effect. mem_we=0 whenever wr_ack=0.
- Address arithmetic is modulo 2^ADDR_W (wrap-around allowed). Base for line n equals n*WORDS.

Test Plan:
- Reset mid-FETCH (RESET_N low at word 20) -> all outputs 0 immediately. After release, line_start fetches base 0.
- frame_start, then 3 line_start pulses 200 cycles apart -> fetches at mem_addr 0..49, 50..99, 100..149. lb_addr 0..49 with data matching RAM contents; busy high exactly 50 cycles each.
- wr_req held continuously, line_start pulse -> wr_ack each idle cycle, none during the 50 FETCH cycles. Ack resumes in the DRAIN cycle; no writes lost, RAM contents verified.
- line_start and wr_req in the same cycle -> no ack that cycle; first read at base next cycle; ack on DRAIN cycle.
- Second line_start 10 cycles into a fetch -> underrun=1, fetch restarts at word 0 of base+50. Underrun stays 1 across later frames until reset.
- 601 line_start pulses after frame_start -> 600 fetches (last base 29950). Pulse 601 is ignored with busy staying 0; the next frame_start restores fetches at base 0.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of every non-clock signal around vga_fb_arbiter: VGA timing pulses,
// the drawing write channel, the framebuffer RAM port and the line-buffer write port.
// master = the arbiter; slave = the surrounding system (timing gen, writer, RAM, line buffer).
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int LB_AW  = 6
);
  // timing generator
  logic              frame_start;  // pulse at start of vertical blank
  logic              line_start;   // pulse in horizontal blank: fetch next line
  // drawing writer
  logic              wr_req;       // held with addr/data until wr_ack
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;       // grant; write happens this cycle
  // framebuffer RAM (single port, 1-cycle read latency)
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // line buffer write port
  logic              lb_we;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_wdata;
  // status
  logic              busy;         // line fetch owns the RAM port
  logic              underrun;     // sticky until reset

  modport master (
    input  frame_start, line_start, wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_wdata,
           busy, underrun
  );

  modport slave (
    output frame_start, line_start, wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_wdata,
           busy, underrun
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Purpose: share one single-port framebuffer RAM between scanline prefetch and drawing writes.
// Latency: first read the cycle after line_start; line complete WORDS+1 cycles after line_start.
// Backpressure: wr_req waits (no wr_ack) while a fetch owns the port or line_start is high.
//
// Ports: CLOCK_50 / RESET_N (async, active low) plus bus (vga_fb_arbiter_if.master):
//   frame_start, line_start in; wr_req/wr_addr/wr_data in, wr_ack out;
//   mem_addr/mem_we/mem_wdata out, mem_rdata in; lb_we/lb_addr/lb_wdata out; busy, underrun out.
module vga_fb_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16,
  parameter int WORDS  = 50,
  parameter int LINES  = 600,
  parameter int LB_AW  = 6
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  vga_fb_arbiter_if.master  bus
);

  localparam int LI_W = $clog2(LINES + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] next_base;
  logic [LB_AW-1:0]  word_cnt;
  logic [LI_W-1:0]   line_idx;
  logic              underrun_q;
  logic              lb_we_q;
  logic [LB_AW-1:0]  lb_addr_q;

  logic [LI_W-1:0]   eff_idx;
  logic [ADDR_W-1:0] eff_base;
  logic              start_fetch;
  logic              grant;
  logic [DATA_W-1:0] rd_word;

  // A frame_start coincident with line_start rewinds first, so that fetch uses base 0.
  assign eff_idx     = bus.frame_start ? '0 : line_idx;
  assign eff_base    = bus.frame_start ? '0 : next_base;
  assign start_fetch = bus.line_start && (eff_idx < LI_W'(LINES));

  // Fetch owns the port in FETCH and in the line_start cycle itself. Gating with
  // RESET_N keeps every output at 0 while reset is held, even with wr_req high.
  assign grant = RESET_N && (state != FETCH) && !bus.line_start && bus.wr_req;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      base       <= '0;
      next_base  <= '0;
      word_cnt   <= '0;
      line_idx   <= '0;
      underrun_q <= 1'b0;
      lb_we_q    <= 1'b0;
      lb_addr_q  <= '0;
    end else begin
      // Line-buffer write trails each read by one cycle, tagged with the read index.
      lb_we_q   <= (state == FETCH);
      lb_addr_q <= word_cnt;

      if (bus.line_start && (state == FETCH))
        underrun_q <= 1'b1;

      if (start_fetch) begin
        // Also covers the underrun case: the running fetch is abandoned and
        // restarts at word 0 of the next line.
        base      <= eff_base;
        next_base <= eff_base + ADDR_W'(WORDS);
        line_idx  <= eff_idx + 1'b1;
        word_cnt  <= '0;
        state     <= FETCH;
      end else begin
        if (bus.frame_start) begin
          line_idx  <= '0;
          next_base <= '0;
        end
        case (state)
          FETCH: begin
            if (word_cnt == LB_AW'(WORDS - 1)) begin
              word_cnt <= '0;
              state    <= DRAIN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          default: state <= IDLE;  // DRAIN lasts one cycle; IDLE holds
        endcase
      end
    end
  end

  assign rd_word       = bus.mem_rdata;

  assign bus.busy      = (state == FETCH);
  assign bus.underrun  = underrun_q;
  assign bus.wr_ack    = grant;
  assign bus.mem_we    = grant;
  assign bus.mem_addr  = (state == FETCH) ? (base + ADDR_W'(word_cnt))
                                          : (grant ? bus.wr_addr : '0);
  assign bus.mem_wdata = grant ? bus.wr_data : '0;
  assign bus.lb_we     = lb_we_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.lb_wdata  = lb_we_q ? rd_word : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Purpose: randomized scoreboard bench for vga_fb_arbiter against a line/cycle-level reference.
// Latency: model predicts reads at line_start+1.., lb writes one cycle after each read.
// Backpressure: writer holds wr_req/addr/data until wr_ack (or drops it at random).
module tb_vga_fb_arbiter;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int WORDS = 50;
  localparam int LINES = 600;
  localparam int LBW   = 6;
  localparam int DEPTH = 1 << AW;

  typedef struct { int cyc; int addr; int idx; } rd_t;
  typedef struct { int cyc; int idx;  int data; } lb_t;
  typedef struct { int cyc; int addr; int data; } wr_t;

  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  logic last_ack = 1'b0;
  int   wr_mode = 0;      // 0 none, 1 continuous, 2 random
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  rd_t  rq[$];
  lb_t  lbq[$];
  wr_t  wq[$];
  int   li = 0;
  int   fs_lo = 1;
  int   fs_hi = 0;
  int   ur_from = -1;

  logic [DW-1:0] env_ram [DEPTH];
  logic [DW-1:0] ref_ram [DEPTH];

  vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LB_AW(LBW)) bus ();

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(WORDS), .LINES(LINES), .LB_AW(LBW)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'((i * 40503) ^ (i >> 5) ^ 16'h5a3c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_underrun"},  int'(bus.underrun), 0);
    check({tag, "_wr_ack"},    int'(bus.wr_ack), 0);
    check({tag, "_mem_we"},    int'(bus.mem_we), 0);
    check({tag, "_mem_addr"},  int'(bus.mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
    check({tag, "_lb_we"},     int'(bus.lb_we), 0);
    check({tag, "_lb_addr"},   int'(bus.lb_addr), 0);
    check({tag, "_lb_wdata"},  int'(bus.lb_wdata), 0);
  endtask

  always @(posedge CLOCK_50) cyc++;

  // Framebuffer RAM: write-first-port semantics not needed, read returns old contents.
  initial begin
    for (int i = 0; i < DEPTH; i++) env_ram[i] <= init_word(i);
    bus.mem_rdata <= '0;
    forever begin
      @(posedge CLOCK_50);
      if (bus.mem_we) env_ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= env_ram[bus.mem_addr];
    end
  end

  always @(negedge CLOCK_50) last_ack <= bus.wr_ack;

  // Drawing writer: a request stays stable until acknowledged, unless dropped.
  initial begin
    forever begin
      @(posedge CLOCK_50); #1;
      if (bus.wr_req && !last_ack && wr_mode != 0 &&
          !(wr_mode == 2 && $urandom_range(0, 15) == 0)) begin
        // keep pending request
      end else if (wr_mode == 1 || (wr_mode == 2 && $urandom_range(0, 2) == 0)) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = AW'($urandom);
        bus.wr_data = DW'($urandom);
      end else begin
        bus.wr_req = 1'b0;
      end
    end
  end

  // Reference model: for each cycle's inputs, decide grants and schedule line fetches.
  // A fetch started by line_start in cycle c reads line li at cycles c+1..c+WORDS.
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_ram[i] = init_word(i);
    forever begin
      @(posedge CLOCK_50); #2;
      if (!RESET_N) begin
        rq.delete(); lbq.delete(); wq.delete();
        li = 0; fs_lo = 1; fs_hi = 0; ur_from = -1;
      end else begin
        automatic bit fetching = (cyc >= fs_lo) && (cyc <= fs_hi);
        if (bus.wr_req && !bus.line_start && !fetching) begin
          wq.push_back('{cyc: cyc, addr: int'(bus.wr_addr), data: int'(bus.wr_data)});
          ref_ram[bus.wr_addr] = bus.wr_data;
        end
        if (bus.frame_start) li = 0;
        if (bus.line_start) begin
          if (fetching && ur_from < 0) ur_from = cyc + 1;
          if (li < LINES) begin
            while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
            for (int k = 0; k < WORDS; k++)
              rq.push_back('{cyc: cyc + 1 + k, addr: (li * WORDS + k) % DEPTH, idx: k});
            fs_lo = cyc + 1;
            fs_hi = cyc + WORDS;
            li++;
          end
        end
      end
    end
  end

  // Monitor: pops expectations as they fall due and flags any unexpected activity.
  initial begin
    rd_t e;
    lb_t l;
    wr_t w;
    forever begin
      @(negedge CLOCK_50);
      if (RESET_N === 1'b1) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          e = rq.pop_front();
          check("rd_busy", int'(bus.busy), 1);
          check("rd_addr", int'(bus.mem_addr), e.addr);
          check("rd_we",   int'(bus.mem_we), 0);
          lbq.push_back('{cyc: cyc + 1, idx: e.idx, data: int'(ref_ram[e.addr])});
        end else begin
          check("idle_busy", int'(bus.busy), 0);
        end
        if (lbq.size() > 0 && lbq[0].cyc == cyc) begin
          l = lbq.pop_front();
          check("lb_we",    int'(bus.lb_we), 1);
          check("lb_addr",  int'(bus.lb_addr), l.idx);
          check("lb_wdata", int'(bus.lb_wdata), l.data);
        end else begin
          check("lb_we_idle", int'(bus.lb_we), 0);
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          w = wq.pop_front();
          check("wr_ack",    int'(bus.wr_ack), 1);
          check("wr_we",     int'(bus.mem_we), 1);
          check("wr_addr",   int'(bus.mem_addr), w.addr);
          check("wr_wdata",  int'(bus.mem_wdata), w.data);
        end else begin
          check("no_ack", int'(bus.wr_ack), 0);
          check("no_we",  int'(bus.mem_we), 0);
        end
        check("underrun", int'(bus.underrun), (ur_from >= 0 && cyc >= ur_from) ? 1 : 0);
      end
    end
  end

  task automatic pulse(input logic fs, input logic ls);
    @(posedge CLOCK_50); #1;
    bus.frame_start = fs;
    bus.line_start  = ls;
    @(posedge CLOCK_50); #1;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int mism;
    RESET_N         = 1'b0;
    bus.frame_start = 1'b0;
    bus.line_start  = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_reset_outputs("por");
    @(posedge CLOCK_50); #1;
    RESET_N = 1'b1;
    idle(3);

    // three lines, well spaced
    pulse(1'b1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      pulse(1'b0, 1'b1);
      idle(198);
    end

    // continuous writer across a fetch (line_start coincides with wr_req)
    wr_mode = 1;
    idle(20);
    pulse(1'b0, 1'b1);
    idle(80);

    // underrun: second line_start 10 cycles into the fetch
    wr_mode = 0;
    idle(5);
    pulse(1'b0, 1'b1);
    idle(8);
    pulse(1'b0, 1'b1);
    idle(100);

    // full frame plus one extra line_start, then a new frame
    wr_mode = 2;
    pulse(1'b1, 1'b0);
    for (int n = 0; n < LINES + 1; n++) begin
      pulse(1'b0, 1'b1);
      idle(50);
    end
    idle(20);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    idle(60);

    // reset while word 20 of a fetch is being read
    pulse(1'b0, 1'b1);
    repeat (20) @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b0;
    #1;
    check_reset_outputs("mid_fetch_rst");
    idle(3);
    RESET_N = 1'b1;
    idle(2);
    pulse(1'b0, 1'b1);
    idle(60);

    // random traffic, including coincident frame/line pulses and underruns
    for (int n = 0; n < 40; n++) begin
      wr_mode = $urandom_range(0, 2);
      pulse(($urandom_range(0, 5) == 0), 1'b1);
      idle($urandom_range(2, 110));
    end

    wr_mode = 0;
    idle(100);
    check("rd_queue_left", rq.size(), 0);
    check("lb_queue_left", lbq.size(), 0);
    check("wr_queue_left", wq.size(), 0);
    mism = 0;
    for (int i = 0; i < DEPTH; i++)
      if (env_ram[i] !== ref_ram[i]) mism++;
    check("ram_contents", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
